// File: rtl/sccb_pkg.sv
// Shared types for the SCCB power-up configuration sequencer.
package sccb_pkg;

    typedef enum logic [3:0] {
        IDLE,
        PWRUP,
        FETCH,
        DECODE,
        ISSUE,
        WAIT_DONE,
        GAP,
        DELAY,
        DONE,
        ERROR
    } seq_state_t;

    localparam logic [15:0] END_MARK  = 16'hFFFF;
    localparam logic [7:0]  DELAY_REG = 8'hFE;

    typedef struct packed {
        logic [7:0] reg_addr;
        logic [7:0] data;
    } tbl_entry_t;

endpackage

// File: rtl/sccb_cfg_rom.sv
// Register table ROM, one cycle read latency.
// Entry i lives at INIT[16*i +: 16] as {reg_addr, data}.
module sccb_cfg_rom
    import sccb_pkg::*;
#(
    parameter int TBL_AW = 8,
    parameter logic [16*(2**TBL_AW)-1:0] INIT = '1
) (
    input  logic              clk,
    input  logic [TBL_AW-1:0] addr,
    output tbl_entry_t        rdata
);

    tbl_entry_t rdata_q;
    tbl_entry_t rdata_d;

    always_comb begin
        rdata_d = tbl_entry_t'(INIT[{addr, 4'b0000} +: 16]);
    end

    always_ff @(posedge clk) begin
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sccb_init_seq.sv
// Power-up sequencer: walks the register table and issues SCCB writes
// with delays, NACK retries, end marker and done/error status.
module sccb_init_seq
    import sccb_pkg::*;
#(
    parameter logic [7:0] DEV_ADDR   = 8'h42,
    parameter int         MS_CYCLES  = 100000,
    parameter int         PWRUP_MS   = 1,
    parameter int         GAP_CYCLES = 16,
    parameter int         MAX_RETRY  = 3,
    parameter int         TBL_AW     = 8,
    parameter logic [16*(2**TBL_AW)-1:0] TBL_INIT = '1
) (
    input  logic              axi_clk,
    input  logic              axi_rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [TBL_AW-1:0] err_idx,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [7:0]        cmd_dev,
    output logic [7:0]        cmd_reg,
    output logic [7:0]        cmd_data,
    input  logic              cmd_done,
    input  logic              cmd_nack
);

    localparam int DLY_MAX = 255 * MS_CYCLES;
    localparam int CNT_W   = $clog2(DLY_MAX + 1);
    localparam int RTY_W   = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    localparam logic [CNT_W-1:0] MS_CNT  = CNT_W'(MS_CYCLES);
    localparam logic [CNT_W-1:0] PWR_CNT = CNT_W'(PWRUP_MS * MS_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_CNT = CNT_W'(GAP_CYCLES - 1);
    localparam logic [RTY_W-1:0] MAX_RT  = RTY_W'(MAX_RETRY);

    seq_state_t        state_q, state_d;
    logic [TBL_AW-1:0] idx_q, idx_d;
    logic [RTY_W-1:0]  retry_q, retry_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        cmd_reg_q, cmd_reg_d;
    logic [7:0]        cmd_data_q, cmd_data_d;
    logic [TBL_AW-1:0] err_idx_q, err_idx_d;
    logic              adv;
    tbl_entry_t        entry;

    sccb_cfg_rom #(
        .TBL_AW (TBL_AW),
        .INIT   (TBL_INIT)
    ) u_rom (
        .clk   (axi_clk),
        .addr  (idx_q),
        .rdata (entry)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        retry_d    = retry_q;
        cnt_d      = cnt_q;
        cmd_reg_d  = cmd_reg_q;
        cmd_data_d = cmd_data_q;
        err_idx_d  = err_idx_q;
        adv        = 1'b0;

        unique case (state_q)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    state_d = PWRUP;
                    idx_d   = '0;
                    retry_d = '0;
                    cnt_d   = PWR_CNT;
                end
            end
            PWRUP: begin
                if (cnt_q == '0) state_d = FETCH;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            FETCH: state_d = DECODE;
            DECODE: begin
                if (entry == END_MARK) begin
                    state_d = DONE;
                end else if (entry.reg_addr == DELAY_REG) begin
                    if (entry.data == 8'd0) begin
                        adv = 1'b1;
                    end else begin
                        cnt_d   = CNT_W'(entry.data) * MS_CNT - CNT_W'(1);
                        state_d = DELAY;
                    end
                end else begin
                    cmd_reg_d  = entry.reg_addr;
                    cmd_data_d = entry.data;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                if (cmd_ready) state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (cmd_done) begin
                    if (!cmd_nack) begin
                        retry_d = '0;
                        cnt_d   = GAP_CNT;
                        state_d = GAP;
                    end else if (retry_q < MAX_RT) begin
                        retry_d = retry_q + RTY_W'(1);
                        state_d = ISSUE;
                    end else begin
                        err_idx_d = idx_q;
                        state_d   = ERROR;
                    end
                end
            end
            GAP, DELAY: begin
                if (cnt_q == '0) adv   = 1'b1;
                else             cnt_d = cnt_q - CNT_W'(1);
            end
            default: state_d = IDLE;
        endcase

        // Stepping past the last table slot ends the walk instead of wrapping
        if (adv) begin
            if (&idx_q) begin
                state_d = DONE;
            end else begin
                idx_d   = idx_q + TBL_AW'(1);
                state_d = FETCH;
            end
        end
    end

    always_ff @(posedge axi_clk) begin
        if (!axi_rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            retry_q    <= '0;
            cnt_q      <= '0;
            cmd_reg_q  <= '0;
            cmd_data_q <= '0;
            err_idx_q  <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            retry_q    <= retry_d;
            cnt_q      <= cnt_d;
            cmd_reg_q  <= cmd_reg_d;
            cmd_data_q <= cmd_data_d;
            err_idx_q  <= err_idx_d;
        end
    end

    assign busy      = !(state_q inside {IDLE, DONE, ERROR});
    assign done      = (state_q == DONE);
    assign err       = (state_q == ERROR);
    assign err_idx   = err_idx_q;
    assign cmd_valid = (state_q == ISSUE);
    assign cmd_dev   = DEV_ADDR;
    assign cmd_reg   = cmd_reg_q;
    assign cmd_data  = cmd_data_q;

endmodule

// File: tb/tb_sccb_init_seq.sv
// Directed bench for sccb_init_seq with a small SCCB master model.
module tb_sccb_init_seq;

    localparam int MS  = 10;
    localparam int GAP = 16;
    localparam int AW  = 3;

    // entry7 .. entry0
    localparam logic [16*8-1:0] TBL = {
        16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h2055,
        16'hFE03, 16'h3344, 16'h1101, 16'h1280
    };

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          busy, done, err;
    logic [AW-1:0] err_idx;
    logic          cmd_valid;
    logic          cmd_ready = 1'b1;
    logic [7:0]    cmd_dev, cmd_reg, cmd_data;
    logic          cmd_done = 1'b0;
    logic          cmd_nack = 1'b0;

    sccb_init_seq #(
        .DEV_ADDR   (8'h42),
        .MS_CYCLES  (MS),
        .PWRUP_MS   (1),
        .GAP_CYCLES (GAP),
        .MAX_RETRY  (3),
        .TBL_AW     (AW),
        .TBL_INIT   (TBL)
    ) dut (
        .axi_clk   (clk),
        .axi_rst_n (rst_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_idx   (err_idx),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_dev   (cmd_dev),
        .cmd_reg   (cmd_reg),
        .cmd_data  (cmd_data),
        .cmd_done  (cmd_done),
        .cmd_nack  (cmd_nack)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // master model state and transaction log
    int          cyc = 0;
    int          ready_low = 0;
    int          low_cnt = 0;
    int          low_seen = 0;
    int          done_cnt = 0;
    int          nack_mode = 0;
    int          n_acc = 0;
    int          n_done = 0;
    int          viol = 0;
    int          cnt11 = 0;
    int          start_cyc = 0;
    logic [7:0]  last_reg = 8'h00;
    logic [23:0] held = '0;
    logic        held_v = 1'b0;
    logic        prev_acc = 1'b0;
    logic [23:0] acc_pl [32];
    int          acc_cyc [32];
    int          done_cyc [32];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        cmd_done = 1'b0;
        cmd_nack = 1'b0;
        if (!rst_n) begin
            done_cnt  = 0;
            cmd_ready = 1'b1;
            low_cnt   = 0;
            held_v    = 1'b0;
            prev_acc  = 1'b0;
        end else begin
            if (prev_acc && cmd_valid) viol++;
            prev_acc = 1'b0;
            if (done_cnt > 0) begin
                done_cnt--;
                if (done_cnt == 0) begin
                    cmd_done = 1'b1;
                    cmd_nack = (nack_mode == 1 && last_reg == 8'h11 && cnt11 <= 2)
                            || (nack_mode == 2 && last_reg == 8'h33);
                    if (n_done < 32) done_cyc[n_done] = cyc;
                    n_done++;
                end
            end
            if (cmd_valid) begin
                if (held_v && {cmd_dev, cmd_reg, cmd_data} != held) viol++;
                held      = {cmd_dev, cmd_reg, cmd_data};
                held_v    = 1'b1;
                cmd_ready = (low_cnt >= ready_low);
                if (!cmd_ready) begin
                    low_cnt++;
                    low_seen++;
                end else begin
                    if (n_acc < 32) begin
                        acc_pl[n_acc]  = held;
                        acc_cyc[n_acc] = cyc;
                    end
                    n_acc++;
                    last_reg = cmd_reg;
                    if (cmd_reg == 8'h11) cnt11++;
                    done_cnt  = 20;
                    prev_acc  = 1'b1;
                    held_v    = 1'b0;
                    ready_low = 0;
                    low_cnt   = 0;
                end
            end else begin
                cmd_ready = 1'b1;
                held_v    = 1'b0;
            end
        end
    end

    function automatic int count_reg(input logic [7:0] r);
        int n = 0;
        for (int i = 0; i < 32 && i < n_acc; i++)
            if (acc_pl[i][15:8] == r) n++;
        return n;
    endfunction

    task automatic clear_log();
        @(posedge clk);
        n_acc    = 0;
        n_done   = 0;
        viol     = 0;
        cnt11    = 0;
        low_seen = 0;
        low_cnt  = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start     = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(input int lim);
        int n = 0;
        while (!(done || err) && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk("end_reached", 32'(done || err), 1);
    endtask

    task automatic wait_acc(input int want, input int lim);
        int n = 0;
        while (n_acc < want && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk("acc_reached", 32'(n_acc >= want), 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_flags", {busy, done, err, cmd_valid}, 0);
        chk("rst_err_idx", 32'(err_idx), 0);
        chk("rst_payload", {cmd_reg, cmd_data}, 0);
        chk("rst_dev", 32'(cmd_dev), 32'h42);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // plain walk with a delay entry, always-ready master
        clear_log();
        pulse_start();
        chk("busy_start", 32'(busy), 1);
        wait_end(2000);
        chk("a_n_acc", n_acc, 4);
        chk("a_pl0", acc_pl[0], 24'h421280);
        chk("a_pl1", acc_pl[1], 24'h421101);
        chk("a_pl2", acc_pl[2], 24'h423344);
        chk("a_pl3", acc_pl[3], 24'h422055);
        chk("a_pwrup_lat", acc_cyc[0] - start_cyc, 13);
        chk("a_gap", acc_cyc[1] - done_cyc[0], 19);
        chk("a_dly_gap", acc_cyc[3] - done_cyc[2], 30 + GAP + 5);
        chk("a_end", {done, busy, err}, 3'b100);
        chk("a_hs_viol", viol, 0);

        // ready withheld for 7 cycles on the first write
        clear_log();
        ready_low = 7;
        pulse_start();
        wait_end(2000);
        chk("b_low_cycles", low_seen, 7);
        chk("b_acc12", count_reg(8'h12), 1);
        chk("b_pl0", acc_pl[0], 24'h421280);
        chk("b_stable", viol, 0);
        chk("b_n_acc", n_acc, 4);
        chk("b_done", 32'(done), 1);

        // two NACKs on entry 1, then ACK
        clear_log();
        nack_mode = 1;
        pulse_start();
        wait_end(3000);
        chk("c_issue11", count_reg(8'h11), 3);
        chk("c_pl3", acc_pl[3], 24'h421101);
        chk("c_n_acc", n_acc, 6);
        chk("c_end", {done, err}, 2'b10);

        // NACK forever on entry 2
        clear_log();
        nack_mode = 2;
        pulse_start();
        wait_end(3000);
        nack_mode = 0;
        chk("d_issue33", count_reg(8'h33), 4);
        chk("d_n_acc", n_acc, 6);
        chk("d_end", {err, busy, done}, 3'b100);
        chk("d_err_idx", 32'(err_idx), 2);

        // start ignored while busy, then reset during WAIT_DONE
        clear_log();
        pulse_start();
        chk("e_err_clr", 32'(err), 0);
        wait_acc(1, 200);
        repeat (3) @(negedge clk);
        pulse_start();
        wait_acc(2, 200);
        chk("e_no_restart", acc_pl[1], 24'h421101);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("e_rst_flags", {busy, done, err, cmd_valid}, 0);
        chk("e_rst_err_idx", 32'(err_idx), 0);
        chk("e_rst_payload", {cmd_reg, cmd_data}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        chk("e_idle", {busy, cmd_valid, done}, 0);
        chk("e_no_resume", n_acc, 2);
        clear_log();
        pulse_start();
        wait_end(2000);
        chk("e_replay_pl0", acc_pl[0], 24'h421280);
        chk("e_replay_n", n_acc, 4);
        chk("e_replay_done", 32'(done), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sccb_init_seq.md
Name: sccb_init_seq

Overview:
- Power-up configuration sequencer for the camera's SCCB register interface.
- Walks a register table of {reg_addr, data} entries held in a sub-module ROM and issues one write per entry to the SCCB master (sccb_ctrl_01 class) over a valid/ready + done/nack handshake.
- Supports timed delay entries, per-write retry on NACK, an end marker, and completion/error status for the PS-side AXI wrapper.

Parameters:
- DEV_ADDR, 8'h42, SCCB 8-bit write device address placed on every command.
- MS_CYCLES, 100000, axi_clk cycles per millisecond (100 MHz). Benches override with a small value.
- PWRUP_MS, 1, delay in ms after start before the first write.
- GAP_CYCLES, 16, idle cycles between a write's cmd_done and the next fetch.
- MAX_RETRY, 3, number of re-issues after a NACK before declaring an error.
- TBL_AW, 8, table address width (table depth 2^TBL_AW).

Ports:
- axi_clk  in  1  system clock.
- axi_rst_n  in  1  synchronous, active-low reset.
- start  in  1  single-cycle pulse; begins the sequence from index 0.
- busy  out  1  high from the cycle after an accepted start until DONE or ERROR.
- done  out  1  level; high once the end marker (or table end) is reached; cleared by start.
- err  out  1  level; high when retries are exhausted; cleared by start.
- err_idx  out  TBL_AW  table index of the failing entry; valid while err=1.
- cmd_valid  out  1  write request to the SCCB master.
- cmd_ready  in  1  master accepts the request.
- cmd_dev  out  8  device address (= DEV_ADDR).
- cmd_reg  out  8  register address.
- cmd_data  out  8  write data.
- cmd_done  in  1  pulse; master finished the transaction.
- cmd_nack  in  1  qualified by cmd_done; 1 means the slave did not acknowledge.

Behaviour:
- Reset (sync, axi_rst_n=0 at a rising edge):
  - State is IDLE.
  - busy, done, err, cmd_valid are 0. err_idx, cmd_reg and cmd_data are 0.
  - Index, retry and delay counters are cleared.
  - Reset mid-operation takes effect at that edge: cmd_valid drops and nothing resumes.
- States: IDLE, PWRUP, FETCH, DECODE, ISSUE, WAIT_DONE, GAP, DELAY, DONE, ERROR.
- IDLE/DONE/ERROR + start=1: clear done, err, index and retry; go to PWRUP; busy=1 next cycle. start in any other state is ignored.
- PWRUP: count PWRUP_MS*MS_CYCLES cycles, then go to FETCH.
- FETCH: present index to the ROM. The ROM has one cycle of read latency, so the entry is valid in DECODE.
- DECODE:
  - Entry 16'hFFFF: end marker, go to DONE.
  - reg=8'hFE: delay entry, load data ms, go to DELAY. data=0 means zero delay, proceed directly.
  - Otherwise latch cmd_reg/cmd_data and go to ISSUE.
- ISSUE: cmd_valid=1 with payload held stable until a cycle with cmd_ready=1. That cycle is the accept; cmd_valid=0 the next cycle; go to WAIT_DONE.
- WAIT_DONE: wait for cmd_done, with no timeout (the master guarantees completion).
  - cmd_nack=0: reset retry, go to GAP.
  - cmd_nack=1 and retry<MAX_RETRY: retry++, re-enter ISSUE with the same payload.
  - cmd_nack=1 and retry=MAX_RETRY: err_idx=index, go to ERROR.
- GAP: wait GAP_CYCLES, then index++ and go to FETCH.
- DELAY: wait data*MS_CYCLES cycles, then index++ and go to FETCH.
- Table wrap: if index++ would wrap from 2^TBL_AW-1 to 0, go to DONE instead.
- DONE: done=1, busy=0. ERROR: err=1, busy=0. Both hold until start or reset.
- cmd_done outside WAIT_DONE is ignored.
- Delay counter width: ceil(log2(255*MS_CYCLES+1)); no overflow allowed.

Decomposition:
- Package sccb_pkg:
  - state enum;
  - END_MARK=16'hFFFF, DELAY_REG=8'hFE;
  - table entry typedef {reg[7:0], data[7:0]}.
- Sub-module sccb_cfg_rom (TBL_AW parameter, registered output, 1-cycle latency, contents from an init file). Benches load their own file.

Test Plan:
- Table {12,80},{11,01},{FFFF}, MS_CYCLES=10, PWRUP_MS=1, always-ready master, done 20 cycles after accept:
  - exactly 2 accepts, payloads (42,12,80) then (42,11,01);
  - first accept no earlier than 10 cycles after start;
  - done=1, busy=0 at end.
- cmd_ready held low 7 cycles: cmd_valid stays high with a stable payload; exactly one accept is recorded.
- Entry {FE,03} between two writes with MS_CYCLES=10: gap between the first cmd_done and the second accept is ≥ 30+GAP_CYCLES cycles.
- NACK on the first two attempts of entry 1, then ACK: entry 1 is issued 3 times and the sequence reaches done.
- NACK forever on entry 2 with MAX_RETRY=3: 4 issues of entry 2, then err=1, err_idx=2, busy=0, done=0.
- Reset asserted in WAIT_DONE and start pulsed during busy:
  - reset clears all outputs at the next edge;
  - a start while busy causes no restart;
  - a new start after reset replays from index 0.
